// File: rtl/pcie_tx_top_if.sv
// Link-layer to PHY beat bus: 64 bytes per beat with per-byte valid and framing markers.
interface pcie_tx_top_if;
  logic         lp_irdy;
  logic         pl_trdy;
  logic [511:0] lp_data;
  logic [63:0]  lp_valid;
  logic [63:0]  lp_dlpstart;
  logic [63:0]  lp_dlpend;
  logic [63:0]  lp_tlpstart;
  logic [63:0]  lp_tlpend;

  modport master (output lp_irdy, lp_data, lp_valid, lp_dlpstart, lp_dlpend,
                  lp_tlpstart, lp_tlpend, input pl_trdy);
  modport slave  (input lp_irdy, lp_data, lp_valid, lp_dlpstart, lp_dlpend,
                  lp_tlpstart, lp_tlpend, output pl_trdy);
endinterface

// File: rtl/pcie_tx_top.sv
// x16 PCIe transmit PHY: TX half of the LTSSM (detect, TS1/TS2 ordered sets) and L0 beat striping.
module pcie_tx_top #(
  parameter int QUIET_CYCLES = 12,
  parameter int TS_COUNT     = 16
) (
  input  logic         pclk,
  input  logic         reset_n,
  pcie_tx_top_if.slave lpIf,
  input  logic [47:0]  RxStatus,
  input  logic [15:0]  PhyStatus,
  output logic [15:0]  TxDetectRx_Loopback,
  output logic [63:0]  PowerDown,
  output logic [15:0]  TxElecIdle,
  output logic [15:0]  detected_lanes,
  output logic         WriteDetectLanesFlag,
  input  logic [3:0]   SetTXState,
  output logic         TXFinishFlag,
  output logic [3:0]   TXExitTo,
  output logic [7:0]   WriteLinkNum,
  output logic         WriteLinkNumFlag,
  input  logic [7:0]   ReadLinkNum,
  output logic [31:0]  TxData1, TxData2, TxData3, TxData4, TxData5, TxData6, TxData7, TxData8,
                       TxData9, TxData10, TxData11, TxData12, TxData13, TxData14, TxData15, TxData16,
  output logic [3:0]   TxDataValid1, TxDataValid2, TxDataValid3, TxDataValid4,
                       TxDataValid5, TxDataValid6, TxDataValid7, TxDataValid8,
                       TxDataValid9, TxDataValid10, TxDataValid11, TxDataValid12,
                       TxDataValid13, TxDataValid14, TxDataValid15, TxDataValid16,
  output logic [3:0]   TxDataK1, TxDataK2, TxDataK3, TxDataK4, TxDataK5, TxDataK6, TxDataK7, TxDataK8,
                       TxDataK9, TxDataK10, TxDataK11, TxDataK12, TxDataK13, TxDataK14, TxDataK15, TxDataK16
);

  localparam logic [3:0] DETECT_QUIET    = 4'b0000;
  localparam logic [3:0] DETECT_ACTIVE   = 4'b0001;
  localparam logic [3:0] POLLING_ACTIVE  = 4'b0010;
  localparam logic [3:0] POLLING_CONFIG  = 4'b0011;
  localparam logic [3:0] CFG_LW_START    = 4'b0100;
  localparam logic [3:0] CFG_COMPLETE    = 4'b1000;
  localparam logic [3:0] CFG_IDLE        = 4'b1001;
  localparam logic [3:0] L0              = 4'b1010;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;

  logic [3:0]   stateReg;
  logic [7:0]   stateCnt;
  logic [1:0]   wordIdx;
  logic         done;
  logic         detDone;
  logic [511:0] txData;
  logic [63:0]  txValid;
  logic [63:0]  txK;

  logic [15:0]  detNow;
  logic [63:0]  byteMask;
  logic [511:0] wordMask;
  logic [63:0]  markerOr;
  logic         isTs;
  logic         inP0;
  logic         linkPad;
  logic [7:0]   tsFill;
  logic [35:0]  tsSym;

  // Returns {K flags, data} for one 4-symbol word of a TS1/TS2 ordered set.
  function automatic logic [35:0] tsWord(input logic [1:0] idx, input logic [7:0] link,
                                         input logic linkIsK, input logic [7:0] fill);
    case (idx)
      2'd0:    tsWord = {1'b0, 1'b1, linkIsK, 1'b1, 8'h00, SYM_PAD, link, SYM_COM};
      2'd1:    tsWord = {4'b0000, fill, fill, 8'h00, 8'h02};
      default: tsWord = {4'b0000, fill, fill, fill, fill};
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    detNow   = '0;
    byteMask = '0;
    wordMask = '0;
    for (int i = 0; i < 16; i++) begin
      detNow[i]          = (RxStatus[3*i +: 3] == 3'b011);
      byteMask[4*i +: 4] = {4{detected_lanes[i]}};
      wordMask[32*i +: 32] = {32{detected_lanes[i]}};
    end
  end

  assign markerOr = lpIf.lp_dlpstart | lpIf.lp_dlpend | lpIf.lp_tlpstart | lpIf.lp_tlpend;
  assign isTs     = (stateReg >= POLLING_ACTIVE) && (stateReg <= CFG_IDLE);
  assign inP0     = (stateReg >= POLLING_ACTIVE) && (stateReg <= L0);
  assign linkPad  = (stateReg == POLLING_ACTIVE) || (stateReg == CFG_LW_START);
  assign tsFill   = (stateReg == POLLING_CONFIG || stateReg == CFG_COMPLETE) ? TS2_ID : TS1_ID;
  assign tsSym    = tsWord(wordIdx, linkPad ? SYM_PAD : ReadLinkNum, linkPad, tsFill);

  assign lpIf.pl_trdy        = (stateReg == L0);
  assign PowerDown           = inP0 ? 64'h0 : {16{4'b0010}};
  assign TxElecIdle          = inP0 ? ~detected_lanes : 16'hFFFF;
  assign TxDetectRx_Loopback = (stateReg == DETECT_ACTIVE && !detDone) ? 16'hFFFF : 16'h0000;
  assign WriteLinkNum        = 8'h00;

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_n) begin
      stateReg             <= DETECT_QUIET;
      stateCnt             <= '0;
      wordIdx              <= '0;
      done                 <= 1'b0;
      detDone              <= 1'b0;
      txData               <= '0;
      txValid              <= '0;
      txK                  <= '0;
      detected_lanes       <= '0;
      WriteDetectLanesFlag <= 1'b0;
      TXFinishFlag         <= 1'b0;
      TXExitTo             <= '0;
      WriteLinkNumFlag     <= 1'b0;
    end else begin
      TXFinishFlag         <= 1'b0;
      WriteDetectLanesFlag <= 1'b0;
      WriteLinkNumFlag     <= 1'b0;
      txData               <= '0;
      txValid              <= '0;
      txK                  <= '0;
      if (SetTXState != stateReg) begin
        // A new command restarts the sequencer from a clean slate.
        stateReg         <= SetTXState;
        stateCnt         <= '0;
        wordIdx          <= '0;
        done             <= 1'b0;
        detDone          <= 1'b0;
        WriteLinkNumFlag <= (SetTXState == CFG_LW_START);
      end else begin
        case (stateReg)
          DETECT_QUIET: begin
            if (!done) begin
              if (stateCnt == 8'(QUIET_CYCLES - 1)) begin
                done         <= 1'b1;
                TXFinishFlag <= 1'b1;
                TXExitTo     <= DETECT_ACTIVE;
              end else begin
                stateCnt <= stateCnt + 8'd1;
              end
            end
          end
          DETECT_ACTIVE: begin
            if (!done) begin
              if (detDone) begin
                done         <= 1'b1;
                TXFinishFlag <= 1'b1;
                TXExitTo     <= (|detected_lanes) ? POLLING_ACTIVE : DETECT_QUIET;
              end else if (PhyStatus == 16'hFFFF) begin
                detected_lanes       <= detNow;
                WriteDetectLanesFlag <= 1'b1;
                detDone              <= 1'b1;
              end
            end
          end
          L0: begin
            if (lpIf.lp_irdy) begin
              txData  <= lpIf.lp_data;
              txValid <= lpIf.lp_valid & byteMask;
              txK     <= markerOr;
            end else begin
              txValid <= byteMask;
            end
          end
          default: begin
            if (isTs && !done) begin
              if (stateCnt == 8'(TS_COUNT)) begin
                done         <= 1'b1;
                TXFinishFlag <= 1'b1;
                TXExitTo     <= stateReg + 4'd1;
              end else begin
                txData  <= {16{tsSym[31:0]}} & wordMask;
                txK     <= {16{tsSym[35:32]}} & byteMask;
                txValid <= byteMask;
                wordIdx <= wordIdx + 2'd1;
                if (wordIdx == 2'd3) stateCnt <= stateCnt + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign {TxData16, TxData15, TxData14, TxData13, TxData12, TxData11, TxData10, TxData9,
          TxData8, TxData7, TxData6, TxData5, TxData4, TxData3, TxData2, TxData1} = txData;
  assign {TxDataValid16, TxDataValid15, TxDataValid14, TxDataValid13,
          TxDataValid12, TxDataValid11, TxDataValid10, TxDataValid9,
          TxDataValid8, TxDataValid7, TxDataValid6, TxDataValid5,
          TxDataValid4, TxDataValid3, TxDataValid2, TxDataValid1} = txValid;
  assign {TxDataK16, TxDataK15, TxDataK14, TxDataK13, TxDataK12, TxDataK11, TxDataK10, TxDataK9,
          TxDataK8, TxDataK7, TxDataK6, TxDataK5, TxDataK4, TxDataK3, TxDataK2, TxDataK1} = txK;

endmodule

// File: tb/tb_pcie_tx_top.sv
// Directed bench for pcie_tx_top: detect, ordered-set framing, L0 striping and restart behaviour.
module tb_pcie_tx_top;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [47:0] RxStatus;
  logic [15:0] PhyStatus;
  logic [15:0] TxDetectRx_Loopback;
  logic [63:0] PowerDown;
  logic [15:0] TxElecIdle;
  logic [15:0] detected_lanes;
  logic        WriteDetectLanesFlag;
  logic [3:0]  SetTXState;
  logic        TXFinishFlag;
  logic [3:0]  TXExitTo;
  logic [7:0]  WriteLinkNum;
  logic        WriteLinkNumFlag;
  logic [7:0]  ReadLinkNum;
  logic [31:0] txd [16];
  logic [3:0]  txv [16];
  logic [3:0]  txk [16];

  int vecCnt = 0;
  int errCnt = 0;

  pcie_tx_top_if lpIf ();

  always #5 pclk = ~pclk;

  pcie_tx_top #(.QUIET_CYCLES(12), .TS_COUNT(16)) dut (
    .pclk(pclk), .reset_n(reset_n), .lpIf(lpIf),
    .RxStatus(RxStatus), .PhyStatus(PhyStatus),
    .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown), .TxElecIdle(TxElecIdle),
    .detected_lanes(detected_lanes), .WriteDetectLanesFlag(WriteDetectLanesFlag),
    .SetTXState(SetTXState), .TXFinishFlag(TXFinishFlag), .TXExitTo(TXExitTo),
    .WriteLinkNum(WriteLinkNum), .WriteLinkNumFlag(WriteLinkNumFlag), .ReadLinkNum(ReadLinkNum),
    .TxData1(txd[0]), .TxData2(txd[1]), .TxData3(txd[2]), .TxData4(txd[3]),
    .TxData5(txd[4]), .TxData6(txd[5]), .TxData7(txd[6]), .TxData8(txd[7]),
    .TxData9(txd[8]), .TxData10(txd[9]), .TxData11(txd[10]), .TxData12(txd[11]),
    .TxData13(txd[12]), .TxData14(txd[13]), .TxData15(txd[14]), .TxData16(txd[15]),
    .TxDataValid1(txv[0]), .TxDataValid2(txv[1]), .TxDataValid3(txv[2]), .TxDataValid4(txv[3]),
    .TxDataValid5(txv[4]), .TxDataValid6(txv[5]), .TxDataValid7(txv[6]), .TxDataValid8(txv[7]),
    .TxDataValid9(txv[8]), .TxDataValid10(txv[9]), .TxDataValid11(txv[10]), .TxDataValid12(txv[11]),
    .TxDataValid13(txv[12]), .TxDataValid14(txv[13]), .TxDataValid15(txv[14]), .TxDataValid16(txv[15]),
    .TxDataK1(txk[0]), .TxDataK2(txk[1]), .TxDataK3(txk[2]), .TxDataK4(txk[3]),
    .TxDataK5(txk[4]), .TxDataK6(txk[5]), .TxDataK7(txk[6]), .TxDataK8(txk[7]),
    .TxDataK9(txk[8]), .TxDataK10(txk[9]), .TxDataK11(txk[10]), .TxDataK12(txk[11]),
    .TxDataK13(txk[12]), .TxDataK14(txk[13]), .TxDataK15(txk[14]), .TxDataK16(txk[15])
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Ticks until TXFinishFlag is seen or the budget runs out; returns ticks taken.
  task automatic waitFinish(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (TXFinishFlag) break;
    end
  endtask

  logic [511:0] beat;
  logic [47:0]  rxPattern;
  int           n;

  initial begin
    reset_n          = 1'b1;
    SetTXState       = 4'b0000;
    RxStatus         = '0;
    PhyStatus        = '0;
    ReadLinkNum      = 8'h5A;
    lpIf.lp_irdy     = 1'b0;
    lpIf.lp_data     = '0;
    lpIf.lp_valid    = '0;
    lpIf.lp_dlpstart = '0;
    lpIf.lp_dlpend   = '0;
    lpIf.lp_tlpstart = '0;
    lpIf.lp_tlpend   = '0;

    repeat (5) tick();
    check("rst_elecidle", TxElecIdle, 16'hFFFF);
    check("rst_powerdown", PowerDown, {16{4'b0010}});
    check("rst_finish", TXFinishFlag, 1'b0);
    check("rst_trdy", lpIf.pl_trdy, 1'b0);
    check("rst_txdata1", txd[0], 32'h0);
    check("rst_detect", TxDetectRx_Loopback, 16'h0);
    reset_n = 1'b0;

    // DetectQuiet: finish after exactly 12 cycles
    waitFinish(40, n);
    check("quiet_cycles", n, 12);
    check("quiet_exit", TXExitTo, 4'b0001);
    tick();
    check("quiet_pulse", TXFinishFlag, 1'b0);
    tick();
    check("quiet_hold", TXFinishFlag, 1'b0);

    // DetectActive with no receivers
    SetTXState = 4'b0001;
    tick();
    check("da0_loopback_on", TxDetectRx_Loopback, 16'hFFFF);
    tick();
    check("da0_loopback_hold", TxDetectRx_Loopback, 16'hFFFF);
    check("da0_no_strobe", WriteDetectLanesFlag, 1'b0);
    PhyStatus = 16'hFFFF;
    tick();
    check("da0_wdl", WriteDetectLanesFlag, 1'b1);
    check("da0_lanes", detected_lanes, 16'h0000);
    check("da0_loopback_off", TxDetectRx_Loopback, 16'h0);
    tick();
    check("da0_finish", TXFinishFlag, 1'b1);
    check("da0_exit", TXExitTo, 4'b0000);

    // DetectActive with lane 8 (status 010) and lane 15 (status 000) missing
    SetTXState = 4'b0000;
    tick();
    for (int i = 0; i < 16; i++) rxPattern[3*i +: 3] = 3'b011;
    rxPattern[3*8 +: 3]  = 3'b010;
    rxPattern[3*15 +: 3] = 3'b000;
    RxStatus   = rxPattern;
    SetTXState = 4'b0001;
    tick();
    tick();
    check("da1_wdl", WriteDetectLanesFlag, 1'b1);
    check("da1_lanes", detected_lanes, 16'h7EFF);
    tick();
    check("da1_finish", TXFinishFlag, 1'b1);
    check("da1_exit", TXExitTo, 4'b0010);

    // PollingActive: TS1 with PAD link field
    SetTXState = 4'b0010;
    tick();
    check("pa_powerdown", PowerDown, 64'h0);
    check("pa_elecidle", TxElecIdle, 16'h8100);
    tick();
    check("pa_w0_data", txd[0], 32'h00F7F7BC);
    check("pa_w0_k", txk[0], 4'b0111);
    check("pa_w0_valid", txv[0], 4'hF);
    check("pa_w0_undet_valid", txv[8], 4'h0);
    check("pa_w0_undet_data", txd[8], 32'h0);
    tick();
    check("pa_w1_data", txd[0], 32'h4A4A0002);
    check("pa_w1_k", txk[0], 4'b0000);
    tick();
    check("pa_w2_data", txd[15 - 1], 32'h4A4A4A4A);
    waitFinish(200, n);
    check("pa_len", n, 62);
    check("pa_exit", TXExitTo, 4'b0011);
    tick();
    check("pa_after_valid", txv[0], 4'h0);

    // CfgLinkWidthStart: link number strobe, PAD link, then interrupted
    SetTXState = 4'b0100;
    tick();
    check("lws_wlflag", WriteLinkNumFlag, 1'b1);
    check("lws_wlnum", WriteLinkNum, 8'h00);
    tick();
    check("lws_wlflag_pulse", WriteLinkNumFlag, 1'b0);
    check("lws_w0_data", txd[0], 32'h00F7F7BC);
    check("lws_w0_k", txk[0], 4'b0111);
    repeat (5) tick();

    // CfgLinkWidthAccept mid-sequence: restarts at word 0 with link number
    SetTXState = 4'b0101;
    tick();
    tick();
    check("lwa_w0_data", txd[0], 32'h00F75ABC);
    check("lwa_w0_k", txk[0], 4'b0101);
    tick();
    check("lwa_w1_data", txd[0], 32'h4A4A0002);
    waitFinish(200, n);
    check("lwa_len", n, 63);
    check("lwa_exit", TXExitTo, 4'b0110);

    // CfgComplete: TS2 identifier
    SetTXState = 4'b1000;
    tick();
    tick();
    check("cc_w0_data", txd[3], 32'h00F75ABC);
    tick();
    check("cc_w1_data", txd[3], 32'h45450002);
    tick();
    check("cc_w2_data", txd[3], 32'h45454545);
    waitFinish(200, n);
    check("cc_len", n, 62);
    check("cc_exit", TXExitTo, 4'b1001);

    // L0: idle fill then one beat
    SetTXState = 4'b1010;
    tick();
    check("l0_trdy", lpIf.pl_trdy, 1'b1);
    tick();
    check("l0_idle_data", txd[0], 32'h0);
    check("l0_idle_valid", txv[0], 4'hF);
    check("l0_idle_undet", txv[15], 4'h0);
    for (int i = 0; i < 16; i++) beat[32*i +: 32] = $urandom;
    lpIf.lp_irdy        = 1'b1;
    lpIf.lp_data        = beat;
    lpIf.lp_valid       = 64'h0123_4567_89AB_CDEF;
    lpIf.lp_tlpstart    = 64'h1;
    lpIf.lp_tlpend      = 64'h1 << 9;
    tick();
    lpIf.lp_irdy     = 1'b0;
    lpIf.lp_tlpstart = '0;
    lpIf.lp_tlpend   = '0;
    check("l0_d1", txd[0], beat[31:0]);
    check("l0_d16", txd[15], beat[511:480]);
    check("l0_k1", txk[0], 4'b0001);
    check("l0_k3", txk[2], 4'b0010);
    check("l0_v2", txv[1], 4'hE);
    check("l0_v9_undet", txv[8], 4'h0);
    check("l0_nofinish", TXFinishFlag, 1'b0);
    tick();
    check("l0_after_data", txd[0], 32'h0);
    check("l0_after_k", txk[2], 4'h0);

    // Reset in the middle of L0
    lpIf.lp_irdy = 1'b1;
    reset_n      = 1'b1;
    tick();
    check("rst2_trdy", lpIf.pl_trdy, 1'b0);
    check("rst2_data", txd[0], 32'h0);
    check("rst2_elecidle", TxElecIdle, 16'hFFFF);
    check("rst2_powerdown", PowerDown, {16{4'b0010}});
    check("rst2_lanes", detected_lanes, 16'h0);
    lpIf.lp_irdy = 1'b0;
    reset_n      = 1'b0;
    tick();
    check("rst2_reenter_trdy", lpIf.pl_trdy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
